debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel debouncer with rising/falling edge pulses and optional long-press detection. It succeeds the single-channel 100 ms debouncer. Every channel has its own 2-flop synchronizer, lock-out FSM and counter, so raw switch/button pins can connect directly. It sits between board-level pushbuttons/switches and the application FSMs.

## Interface
- `CH`, 4: number of independent channels (≥1).
- `DB_CYCLES`, 5_000_000: lock-out time in clk cycles (100 ms at 50 MHz); ≥2.
- `HOLD_CYCLES`, 50_000_000: long-press threshold in clk cycles, measured from entry to HIGH_WAIT; > `DB_CYCLES`. Used only with `DEBOUNCE_HOLD_EN`.
- `CNT_W`, derived: `$clog2(max(DB_CYCLES, HOLD_CYCLES))`. Localparam, not overridable.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `signal` in CH: raw asynchronous inputs, active-high.
- `level` out CH: debounced level per channel.
- `r_edg` out CH: 1-cycle pulse on each debounced rising edge.
- `f_edg` out CH: 1-cycle pulse on each debounced falling edge.
- `ready` out CH: channel is in IDLE, meaning it is armed for a new press.
- `hold` out CH: 1-cycle long-press pulse. Constant 0 when `DEBOUNCE_HOLD_EN` is undefined.

## Operation
- Each channel `i` has a 2-flop synchronizer `signal[i]` -> `s[i]`. The FSM sees only `s[i]`.
- Each channel has an FSM with 4 states, a `CNT_W`-bit counter and a hold-done flag:
  - IDLE: `ready`=1, `level`=0. If `s`=1: go to HIGH_LOCK, clear the counter, pulse `r_edg`.
  - HIGH_LOCK: `level`=1, input ignored. Counter increments. When the counter reaches `DB_CYCLES-1`: go to HIGH_WAIT, clear the counter, clear hold-done.
  - HIGH_WAIT: `level`=1. If `s`=0: go to LOW_LOCK, clear the counter, pulse `f_edg`. Otherwise the counter increments and saturates at `HOLD_CYCLES-1`.
  - LOW_LOCK: `level`=0, input ignored. Counter increments. When it reaches `DB_CYCLES-1`: go to IDLE.
- Long press (only with the macro): in HIGH_WAIT, when the counter equals `HOLD_CYCLES-1` and hold-done=0, pulse `hold` and set hold-done. This gives at most one `hold` per press.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Glitch rules:
  - A 1-cycle high seen in IDLE still produces a full press: `level` is high for at least `DB_CYCLES` cycles.
  - Bounces during either lock state are ignored.
- Outputs are registered. Every output is a function of registered state only; there is no combinational path from `signal`.

## Timing
- Reset values: all states IDLE, counters 0, synchronizers 0, hold-done 0. Outputs: `level`=0, `r_edg`=0, `f_edg`=0, `hold`=0, `ready`=all 1.
- Latency: `signal[i]` goes high before clk edge E0 and is held. `s[i]`=1 after E1. `level[i]`=1 and `r_edg[i]`=1 after E2, so `r_edg` is high during cycle E2..E3.
- Falling-edge latency is the same, 2 edges: `f_edg` pulses and `level` falls together.
- Minimum `level` high time is `DB_CYCLES`+1 cycles. Minimum low time before re-arm is `DB_CYCLES` cycles.
- `hold` fires `HOLD_CYCLES` cycles after entry to HIGH_WAIT, i.e. `DB_CYCLES+HOLD_CYCLES` cycles after `r_edg`.
- The counter never wraps:
  - Lock states stop it at `DB_CYCLES-1`.
  - HIGH_WAIT saturates it at `HOLD_CYCLES-1`.
- Reset asserted mid-press: all outputs go to reset values immediately (asynchronously). No `f_edg` is generated. After release, a still-high input produces a fresh `r_edg` 2 edges after the first clk edge.

## Configuration
- `DEBOUNCE_HOLD_EN` defined: `hold` logic, hold-done flags and HIGH_WAIT counting are compiled in.
- `DEBOUNCE_HOLD_EN` undefined:
  - The counter is idle in HIGH_WAIT.
  - `CNT_W` derives from `DB_CYCLES` only.
  - `hold` is tied to 0.
  - All other behaviour is identical.

## Test plan
Parameters: CH=2, DB_CYCLES=8, HOLD_CYCLES=32, `DEBOUNCE_HOLD_EN` defined.
- Reset: `rst_n`=0 with inputs toggling -> `level`=0, edges=0, `hold`=0, `ready`=2'b11. After release, no pulses while inputs stay 0.
- Clean press on ch0, 100 cycles -> `r_edg[0]` for 1 cycle 2 edges after the rise. `hold[0]` for 1 cycle exactly 40 cycles after `r_edg`. On release, `f_edg[0]` 2 edges later and `level[0]` falls together. `ready[0]` returns 8 cycles later.
- Bouncy press: 5 toggles within 6 cycles, then stable high 20 cycles -> exactly one `r_edg`, one `f_edg`, no `hold`, and `level` stays high with no glitch.
- Glitch: 1-cycle high in IDLE -> one `r_edg` and `level` high for 9 cycles, then one `f_edg`.
- Independence: ch0 and ch1 pressed on the same cycle -> `r_edg`=2'b11 in the same cycle. Releasing only ch1 -> `f_edg`=2'b10.
- Reset mid-HIGH_WAIT with input held high -> outputs cleared with no `f_edg`. After release, `r_edg` reappears 2 edges after the first clk edge.

Source files
------------

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel pushbutton/switch debouncer. Each channel has a 2-flop
// synchronizer, a 4-state lock-out FSM and its own counter, so raw pins can
// connect directly. A debounced press is reported as soon as the synchronized
// input goes high. Further input changes are ignored for DB_CYCLES clocks on
// each transition.
//
// Optional feature: define DEBOUNCE_HOLD_EN to compile in long-press
// detection. A single `hold` pulse is produced HOLD_CYCLES clocks after the
// channel enters HIGH_WAIT. When the macro is not defined, `hold` is tied to 0
// and the counter does not run in HIGH_WAIT.
//
// Parameters:
//   CH          number of independent channels (>= 1)
//   DB_CYCLES   lock-out time in clk cycles (>= 2)
//   HOLD_CYCLES long-press threshold in clk cycles (> DB_CYCLES)
//
// Ports:
//   clk    in  1   clock
//   rst_n  in  1   asynchronous active-low reset
//   signal in  CH  raw asynchronous inputs, active-high
//   level  out CH  debounced level
//   r_edg  out CH  1-cycle pulse on each debounced rising edge
//   f_edg  out CH  1-cycle pulse on each debounced falling edge
//   ready  out CH  channel idle and armed for a new press
//   hold   out CH  1-cycle long-press pulse (0 without DEBOUNCE_HOLD_EN)
// -----------------------------------------------------------------------------
module debounce_multi #(
  parameter int CH          = 4,
  parameter int DB_CYCLES   = 5_000_000,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] signal,
  output logic [CH-1:0] level,
  output logic [CH-1:0] r_edg,
  output logic [CH-1:0] f_edg,
  output logic [CH-1:0] ready,
  output logic [CH-1:0] hold
);

`ifdef DEBOUNCE_HOLD_EN
  localparam int CNT_MAX = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
`else
  localparam int CNT_MAX = DB_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef DEBOUNCE_HOLD_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`endif

  // Reject parameter sets that would let the counter wrap or make
  // long-press detection meaningless.
  if (DB_CYCLES < 2 || HOLD_CYCLES <= DB_CYCLES) begin : g_bad_params
    $error("debounce_multi: need DB_CYCLES >= 2 and HOLD_CYCLES > DB_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HIGH_LOCK = 2'd1,
    HIGH_WAIT = 2'd2,
    LOW_LOCK  = 2'd3
  } state_t;

  // Two-flop synchronizer for every channel.
  logic [CH-1:0] s1_reg;
  logic [CH-1:0] s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s_reg  <= '0;
    end else begin
      s1_reg <= signal;
      s_reg  <= s1_reg;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             r_edg_reg, r_edg_next;
    logic             f_edg_reg, f_edg_next;
`ifdef DEBOUNCE_HOLD_EN
    logic             hold_reg, hold_next;
    logic             hold_done_reg, hold_done_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg     <= IDLE;
        cnt_reg       <= '0;
        r_edg_reg     <= 1'b0;
        f_edg_reg     <= 1'b0;
`ifdef DEBOUNCE_HOLD_EN
        hold_reg      <= 1'b0;
        hold_done_reg <= 1'b0;
`endif
      end else begin
        state_reg     <= state_next;
        cnt_reg       <= cnt_next;
        r_edg_reg     <= r_edg_next;
        f_edg_reg     <= f_edg_next;
`ifdef DEBOUNCE_HOLD_EN
        hold_reg      <= hold_next;
        hold_done_reg <= hold_done_next;
`endif
      end
    end

    always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      r_edg_next     = 1'b0;
      f_edg_next     = 1'b0;
`ifdef DEBOUNCE_HOLD_EN
      hold_next      = 1'b0;
      hold_done_next = hold_done_reg;
`endif
      case (state_reg)
        IDLE: begin
          if (s_reg[gi]) begin
            state_next = HIGH_LOCK;
            cnt_next   = '0;
            r_edg_next = 1'b1;
          end
        end
        HIGH_LOCK: begin
          if (cnt_reg == DB_LAST) begin
            state_next = HIGH_WAIT;
            cnt_next   = '0;
`ifdef DEBOUNCE_HOLD_EN
            hold_done_next = 1'b0;
`endif
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        HIGH_WAIT: begin
          if (!s_reg[gi]) begin
            state_next = LOW_LOCK;
            cnt_next   = '0;
            f_edg_next = 1'b1;
          end
`ifdef DEBOUNCE_HOLD_EN
          else if (cnt_reg != HOLD_LAST) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
          // Saturated counter plus the done flag gives one pulse per press.
          if (cnt_reg == HOLD_LAST && !hold_done_reg) begin
            hold_next      = 1'b1;
            hold_done_next = 1'b1;
          end
`endif
        end
        LOW_LOCK: begin
          if (cnt_reg == DB_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

    // Level and ready decode straight from the state register.
    assign level[gi] = (state_reg == HIGH_LOCK) || (state_reg == HIGH_WAIT);
    assign ready[gi] = (state_reg == IDLE);
    assign r_edg[gi] = r_edg_reg;
    assign f_edg[gi] = f_edg_reg;
`ifdef DEBOUNCE_HOLD_EN
    assign hold[gi]  = hold_reg;
`else
    assign hold[gi]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Bench for debounce_multi with CH=2, DB_CYCLES=8, HOLD_CYCLES=32.
// Each record holds the input for one or more cycles and the outputs expected
// after the clock edges of those cycles. The expected values are queued when
// the input is driven and compared on the following falling clock edge.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

  localparam int CH = 2;

`ifdef DEBOUNCE_HOLD_EN
  localparam logic [1:0] HX = 2'b01;
`else
  localparam logic [1:0] HX = 2'b00;
`endif

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] signal;
  logic [CH-1:0] level;
  logic [CH-1:0] r_edg;
  logic [CH-1:0] f_edg;
  logic [CH-1:0] ready;
  logic [CH-1:0] hold;

  debounce_multi #(
    .CH          (CH),
    .DB_CYCLES   (8),
    .HOLD_CYCLES (32)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .signal (signal),
    .level  (level),
    .r_edg  (r_edg),
    .f_edg  (f_edg),
    .ready  (ready),
    .hold   (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sig;
    int         n;
    logic [1:0] lv;
    logic [1:0] re;
    logic [1:0] fe;
    logic [1:0] rd;
    logic [1:0] hd;
  } vec_t;

  typedef struct {
    int         tag;
    int         row;
    logic [1:0] lv;
    logic [1:0] re;
    logic [1:0] fe;
    logic [1:0] rd;
    logic [1:0] hd;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(string name, int row, logic [1:0] got, logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d cycle %0d: got %b expected %b", name, row, cyc, got, want);
    end
  endfunction

  function automatic void cmp_all(int row, logic [1:0] lv, logic [1:0] re,
                                  logic [1:0] fe, logic [1:0] rd, logic [1:0] hd);
    cmp("level", row, level, lv);
    cmp("r_edg", row, r_edg, re);
    cmp("f_edg", row, f_edg, fe);
    cmp("ready", row, ready, rd);
    cmp("hold",  row, hold,  hd);
  endfunction

  function automatic void add(logic [1:0] sig, int n, logic [1:0] lv, logic [1:0] re,
                              logic [1:0] fe, logic [1:0] rd, logic [1:0] hd);
    vec_t v;
    v.sig = sig; v.n = n; v.lv = lv; v.re = re; v.fe = fe; v.rd = rd; v.hd = hd;
    tbl.push_back(v);
  endfunction

  // Scoreboard: pop every expectation whose target cycle has been reached.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.tag != cyc) begin
        errors++;
        $display("FAIL stale row %0d: compared at cycle %0d expected cycle %0d", e.row, cyc, e.tag);
      end
      cmp_all(e.row, e.lv, e.re, e.fe, e.rd, e.hd);
    end
  end

  // Called in the low phase of the clock; each cycle drives the input for the
  // next rising edge and queues the outputs expected after that edge.
  task automatic run_rows(input int first, input int last);
    exp_t x;
    for (int i = first; i < last; i++) begin
      $display("row %0d: signal=%b for %0d cycles", i, tbl[i].sig, tbl[i].n);
      for (int k = 0; k < tbl[i].n; k++) begin
        signal = tbl[i].sig;
        x.tag = cyc + 1; x.row = i;
        x.lv = tbl[i].lv; x.re = tbl[i].re; x.fe = tbl[i].fe;
        x.rd = tbl[i].rd; x.hd = tbl[i].hd;
        exp_q.push_back(x);
        @(negedge clk);
      end
    end
  endtask

  int s_idle, s_clean, s_bouncy, s_glitch, s_indep, s_pre_rst, s_post_rst, s_end;

  initial begin
    //        sig    n   level  r_edg  f_edg  ready  hold
    s_idle = tbl.size();
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    // Clean 100-cycle press on ch0 with long-press pulse.
    s_clean = tbl.size();
    add(2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
    add(2'b01, 39, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b10, HX);
    add(2'b01, 57, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  2, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00,  7, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    // Bouncy press: 5 toggles, then stable high.
    s_bouncy = tbl.size();
    add(2'b01,  1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b01, 21, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  2, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00,  7, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    // Single-cycle glitch in IDLE still yields a full 9-cycle press.
    s_glitch = tbl.size();
    add(2'b01,  1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b00,  1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
    add(2'b00,  8, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00,  7, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    // Both channels pressed together, ch1 released first.
    s_indep = tbl.size();
    add(2'b11,  2, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b11,  1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 12, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00);
    add(2'b01,  7, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b01,  1, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  2, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00,  7, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  5, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    // Press ch0 into HIGH_WAIT; reset follows.
    s_pre_rst = tbl.size();
    add(2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
    add(2'b01, 13, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    // After reset release with ch0 still high: fresh press, then release.
    s_post_rst = tbl.size();
    add(2'b01,  2, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    add(2'b01,  1, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00);
    add(2'b01,  7, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  2, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  1, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00);
    add(2'b00,  7, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
    add(2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    s_end = tbl.size();

    // Reset held while the inputs toggle: outputs must stay at reset values.
    rst_n  = 1'b0;
    signal = 2'b00;
    for (int i = 0; i < 6; i++) begin
      signal = 2'(i);
      @(negedge clk);
      $display("reset hold: signal=%b", signal);
      cmp_all(-1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    end
    signal = 2'b00;
    rst_n  = 1'b1;

    run_rows(s_idle, s_clean);
    run_rows(s_clean, s_bouncy);
    run_rows(s_bouncy, s_glitch);
    run_rows(s_glitch, s_indep);
    run_rows(s_indep, s_pre_rst);
    run_rows(s_pre_rst, s_post_rst);

    // Asynchronous reset in HIGH_WAIT with the input still high.
    #3 rst_n = 1'b0;
    #1;
    $display("async reset in HIGH_WAIT");
    cmp_all(-2, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp_all(-3, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00);
    end
    rst_n = 1'b1;
    run_rows(s_post_rst, s_end);

    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish by 100000 expected finish");
    $fatal(1, "timeout");
  end

endmodule
